// File: rtl/bsg_counter_set_up_down_sat_if.sv
// Control and status bundle for the set/up/down counter.
// The master drives the requests and the slave (the counter) returns count and status.
interface bsg_counter_set_up_down_sat_if #(
    parameter int width_p      = 16,
    parameter int step_width_p = 4
);
    logic                    set_i;
    logic [width_p-1:0]      val_i;
    logic                    up_i;
    logic                    down_i;
    logic [step_width_p-1:0] step_i;
    logic                    clear_err_i;
    logic [width_p-1:0]      count_r_o;
    logic                    zero_o;
    logic                    ovf_r_o;
    logic                    unf_r_o;
    logic                    tc_r_o;
    logic                    err_r_o;

    modport master (
        output set_i, val_i, up_i, down_i, step_i, clear_err_i,
        input  count_r_o, zero_o, ovf_r_o, unf_r_o, tc_r_o, err_r_o
    );

    modport slave (
        input  set_i, val_i, up_i, down_i, step_i, clear_err_i,
        output count_r_o, zero_o, ovf_r_o, unf_r_o, tc_r_o, err_r_o
    );
endinterface

// File: rtl/bsg_counter_set_up_down_sat.sv
// Up/down counter with synchronous load, variable step, wrap or saturate policy,
// and registered overflow/underflow/terminal-count pulses plus a sticky error flag.
module bsg_counter_set_up_down_sat #(
    parameter int                 width_p      = 16,
    parameter int                 step_width_p = 4,
    parameter int                 saturate_p   = 0,
    parameter logic [width_p-1:0] reset_val_p  = '0
) (
    input logic                         clk_i,
    input logic                         reset_n_i,
    bsg_counter_set_up_down_sat_if.slave bus
);

    logic [width_p-1:0] count_r;
    logic               ovf_r;
    logic               unf_r;
    logic               tc_r;
    logic               err_r;

    logic [width_p-1:0] count_next;
    logic               ovf_next;
    logic               unf_next;
    logic               tc_next;
    logic               err_next;

    logic [width_p:0]   step_ext;
    logic [width_p:0]   sum;
    logic [width_p:0]   diff;

    // One extra bit on each side exposes carry (sum) and borrow (diff).
    assign step_ext = {{(width_p + 1 - step_width_p){1'b0}}, bus.step_i};
    assign sum      = {1'b0, count_r} + step_ext;
    assign diff     = {1'b0, count_r} - step_ext;

    always_comb begin
        count_next = count_r;
        ovf_next   = 1'b0;
        unf_next   = 1'b0;
        tc_next    = 1'b0;
        if (bus.set_i) begin
            count_next = bus.val_i;
        end else if (bus.up_i && bus.down_i) begin
            count_next = count_r;
        end else if (bus.up_i) begin
            if (sum[width_p]) begin
                ovf_next   = 1'b1;
                count_next = (saturate_p != 0) ? {width_p{1'b1}} : sum[width_p-1:0];
            end else begin
                count_next = sum[width_p-1:0];
            end
        end else if (bus.down_i) begin
            if (diff[width_p]) begin
                unf_next   = 1'b1;
                count_next = (saturate_p != 0) ? {width_p{1'b0}} : diff[width_p-1:0];
            end else begin
                count_next = diff[width_p-1:0];
            end
            // Covers a saturating clamp to zero as well as an exact landing.
            tc_next = (count_r != '0) && (count_next == '0);
        end
        err_next = (err_r & ~bus.clear_err_i) | ovf_next | unf_next;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_r <= reset_val_p;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
            tc_r    <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            count_r <= count_next;
            ovf_r   <= ovf_next;
            unf_r   <= unf_next;
            tc_r    <= tc_next;
            err_r   <= err_next;
        end
    end

    assign bus.count_r_o = count_r;
    assign bus.zero_o    = (count_r == '0);
    assign bus.ovf_r_o   = ovf_r;
    assign bus.unf_r_o   = unf_r;
    assign bus.tc_r_o    = tc_r;
    assign bus.err_r_o   = err_r;

endmodule

// File: tb/tb_bsg_counter_set_up_down_sat.sv
// Bench for the set/up/down counter: a wrap instance and a saturate instance share stimulus.
module tb_bsg_counter_set_up_down_sat;

    localparam int    W       = 16;
    localparam int    SW      = 4;
    localparam longint MAXV   = (longint'(1) << W) - 1;

    logic clk_i;
    logic reset_n_i;

    logic          set_s, up_s, down_s, clr_s;
    logic [W-1:0]  val_s;
    logic [SW-1:0] step_s;

    int n_cmp;
    int n_bad;

    bsg_counter_set_up_down_sat_if #(.width_p(W), .step_width_p(SW)) if_w ();
    bsg_counter_set_up_down_sat_if #(.width_p(W), .step_width_p(SW)) if_s ();

    assign if_w.set_i = set_s;  assign if_s.set_i = set_s;
    assign if_w.val_i = val_s;  assign if_s.val_i = val_s;
    assign if_w.up_i = up_s;    assign if_s.up_i = up_s;
    assign if_w.down_i = down_s; assign if_s.down_i = down_s;
    assign if_w.step_i = step_s; assign if_s.step_i = step_s;
    assign if_w.clear_err_i = clr_s; assign if_s.clear_err_i = clr_s;

    bsg_counter_set_up_down_sat #(
        .width_p(W), .step_width_p(SW), .saturate_p(0), .reset_val_p(16'h0005)
    ) dut_w (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .bus(if_w)
    );

    bsg_counter_set_up_down_sat #(
        .width_p(W), .step_width_p(SW), .saturate_p(1), .reset_val_p(16'h0005)
    ) dut_s (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .bus(if_s)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          set;
        logic [15:0] val;
        bit          up;
        bit          down;
        logic [3:0]  step;
        bit          clr;
        logic [15:0] ec;
        bit          eo;
        bit          eu;
        bit          et;
        bit          ee;
    } vec_t;

    vec_t vecs[16];

    // Reference state per policy: index 0 = wrap, 1 = saturate.
    longint m_cnt[2];
    bit     m_err[2];
    bit     m_o[2];
    bit     m_u[2];
    bit     m_t[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_dut(input bit sat, input string tag, input logic [15:0] ec,
                           input bit eo, input bit eu, input bit et, input bit ee);
        logic [15:0] c;
        logic z, o, u, t, e;
        if (sat) begin
            c = if_s.count_r_o; z = if_s.zero_o; o = if_s.ovf_r_o;
            u = if_s.unf_r_o;   t = if_s.tc_r_o; e = if_s.err_r_o;
        end else begin
            c = if_w.count_r_o; z = if_w.zero_o; o = if_w.ovf_r_o;
            u = if_w.unf_r_o;   t = if_w.tc_r_o; e = if_w.err_r_o;
        end
        chk({tag, ".count"}, 32'(c), 32'(ec));
        chk({tag, ".zero"},  32'(z), 32'(ec == 16'h0));
        chk({tag, ".ovf"},   32'(o), 32'(eo));
        chk({tag, ".unf"},   32'(u), 32'(eu));
        chk({tag, ".tc"},    32'(t), 32'(et));
        chk({tag, ".err"},   32'(e), 32'(ee));
    endtask

    task automatic drive(input bit s, input logic [15:0] v, input bit u, input bit d,
                         input logic [3:0] st, input bit c);
        set_s = s; val_s = v; up_s = u; down_s = d; step_s = st; clr_s = c;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Plain integer arithmetic on the policy rules, not on bit slices.
    task automatic ref_step(input int k);
        longint prev;
        longint r;
        prev = m_cnt[k];
        m_o[k] = 1'b0; m_u[k] = 1'b0; m_t[k] = 1'b0;
        if (set_s) begin
            m_cnt[k] = longint'(val_s);
        end else if (up_s && down_s) begin
            m_cnt[k] = prev;
        end else if (up_s) begin
            r = prev + longint'(step_s);
            if (r > MAXV) begin
                m_o[k]   = 1'b1;
                m_cnt[k] = (k == 1) ? MAXV : r - (MAXV + 1);
            end else begin
                m_cnt[k] = r;
            end
        end else if (down_s) begin
            r = prev - longint'(step_s);
            if (r < 0) begin
                m_u[k]   = 1'b1;
                m_cnt[k] = (k == 1) ? 0 : r + (MAXV + 1);
            end else begin
                m_cnt[k] = r;
            end
            m_t[k] = (prev != 0) && (m_cnt[k] == 0);
        end
        m_err[k] = (m_err[k] && !clr_s) || m_o[k] || m_u[k];
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset_n_i = 1'b0;
        drive(0, 16'h0, 1, 0, 4'h7, 0);

        vecs[0]  = '{1, 16'h1234, 0, 0, 4'h0, 0, 16'h1234, 0, 0, 0, 0};
        vecs[1]  = '{1, 16'hFFFE, 0, 0, 4'h0, 0, 16'hFFFE, 0, 0, 0, 0};
        vecs[2]  = '{0, 16'h0000, 1, 0, 4'h3, 0, 16'h0001, 1, 0, 0, 1};
        vecs[3]  = '{0, 16'h0000, 0, 0, 4'h0, 0, 16'h0001, 0, 0, 0, 1};
        vecs[4]  = '{1, 16'h00AA, 1, 0, 4'hF, 0, 16'h00AA, 0, 0, 0, 1};
        vecs[5]  = '{0, 16'h0000, 1, 1, 4'hF, 0, 16'h00AA, 0, 0, 0, 1};
        vecs[6]  = '{0, 16'h0000, 1, 0, 4'h0, 0, 16'h00AA, 0, 0, 0, 1};
        vecs[7]  = '{1, 16'h0003, 0, 0, 4'h0, 0, 16'h0003, 0, 0, 0, 1};
        vecs[8]  = '{0, 16'h0000, 0, 1, 4'h1, 0, 16'h0002, 0, 0, 0, 1};
        vecs[9]  = '{0, 16'h0000, 0, 1, 4'h1, 0, 16'h0001, 0, 0, 0, 1};
        vecs[10] = '{0, 16'h0000, 0, 1, 4'h1, 0, 16'h0000, 0, 0, 1, 1};
        vecs[11] = '{0, 16'h0000, 0, 0, 4'h0, 0, 16'h0000, 0, 0, 0, 1};
        vecs[12] = '{0, 16'h0000, 0, 0, 4'h0, 1, 16'h0000, 0, 0, 0, 0};
        vecs[13] = '{1, 16'hFFFF, 0, 0, 4'h0, 0, 16'hFFFF, 0, 0, 0, 0};
        vecs[14] = '{0, 16'h0000, 1, 0, 4'h1, 1, 16'h0000, 1, 0, 0, 1};
        vecs[15] = '{0, 16'h0000, 0, 1, 4'h1, 0, 16'hFFFF, 0, 1, 0, 1};

        // Reset held for three edges while requests are present.
        repeat (3) tick();
        chk_dut(0, "rst_w", 16'h0005, 0, 0, 0, 0);
        chk_dut(1, "rst_s", 16'h0005, 0, 0, 0, 0);
        drive(0, 16'h0, 0, 0, 4'h0, 0);
        reset_n_i = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].set, vecs[i].val, vecs[i].up, vecs[i].down, vecs[i].step, vecs[i].clr);
            tick();
            chk_dut(0, $sformatf("vec%0d", i), vecs[i].ec, vecs[i].eo, vecs[i].eu,
                    vecs[i].et, vecs[i].ee);
        end

        // Saturating policy corners.
        drive(1, 16'h0002, 0, 0, 4'h0, 1); tick();
        chk_dut(1, "sat_load", 16'h0002, 0, 0, 0, 0);
        drive(0, 16'h0, 0, 1, 4'h5, 0); tick();
        chk_dut(1, "sat_unf", 16'h0000, 0, 1, 1, 1);
        drive(0, 16'h0, 0, 1, 4'h1, 0); tick();
        chk_dut(1, "sat_unf0", 16'h0000, 0, 1, 0, 1);
        drive(1, 16'hFFFE, 0, 0, 4'h0, 0); tick();
        chk_dut(1, "sat_load2", 16'hFFFE, 0, 0, 0, 1);
        drive(0, 16'h0, 1, 0, 4'h3, 0); tick();
        chk_dut(1, "sat_ovf", 16'hFFFF, 1, 0, 0, 1);
        drive(0, 16'h0, 0, 0, 4'h0, 0); tick();
        chk_dut(1, "sat_idle", 16'hFFFF, 0, 0, 0, 1);

        // Asynchronous reset between edges, with an operation in flight.
        drive(0, 16'h0, 1, 0, 4'h9, 0);
        @(posedge clk_i);
        #3 reset_n_i = 1'b0;
        #1;
        chk_dut(0, "arst_w", 16'h0005, 0, 0, 0, 0);
        chk_dut(1, "arst_s", 16'h0005, 0, 0, 0, 0);
        drive(0, 16'h0, 0, 0, 4'h0, 0);
        tick();
        reset_n_i = 1'b1;

        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 5; m_err[k] = 1'b0;
        end

        for (int n = 0; n < 3000; n++) begin
            logic [15:0] v;
            case ($urandom_range(0, 3))
                0: v = 16'h0000;
                1: v = 16'hFFFF - 16'($urandom_range(0, 20));
                2: v = 16'($urandom_range(0, 20));
                default: v = 16'($urandom);
            endcase
            drive($urandom_range(0, 9) == 0, v, 1'($urandom), 1'($urandom),
                  4'($urandom), $urandom_range(0, 7) == 0);
            ref_step(0);
            ref_step(1);
            tick();
            chk_dut(0, "rnd_w", 16'(m_cnt[0]), m_o[0], m_u[0], m_t[0], m_err[0]);
            chk_dut(1, "rnd_s", 16'(m_cnt[1]), m_o[1], m_u[1], m_t[1], m_err[1]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bsg_counter_set_up_down_sat.md
Name: bsg_counter_set_up_down_sat

Overview:
Parametrised up/down counter with synchronous load, variable step, a selectable wrap or saturate policy, and registered overflow/underflow/terminal-count status. It generalises the set/decrement counter into the general-purpose credit, occupancy and timer counter used across the library. It is a single registered datapath with one clock domain and no internal handshake.

Parameters:
width_p, 16, counter width in bits (>=2)
step_width_p, 4, width of step_i; step range 0..2^step_width_p-1 (must be <= width_p)
saturate_p, 0, 0 = modulo-2^width_p wrap; 1 = clamp at 0 and at 2^width_p-1
reset_val_p, 0, value loaded into count_r_o on reset (must fit in width_p)

Ports:
clk_i  in  1  clock, rising edge
reset_n_i  in  1  asynchronous active-low reset
set_i  in  1  load val_i on the next edge; highest priority
val_i  in  width_p  load value
up_i  in  1  increment request
down_i  in  1  decrement request
step_i  in  step_width_p  magnitude applied by up_i/down_i
clear_err_i  in  1  clears sticky err_r_o
count_r_o  out  width_p  registered count
zero_o  out  1  combinational (count_r_o == 0)
ovf_r_o  out  1  one-cycle pulse: last update exceeded 2^width_p-1
unf_r_o  out  1  one-cycle pulse: last update went below 0
tc_r_o  out  1  one-cycle pulse: count reached 0 via a decrement from a nonzero value
err_r_o  out  1  sticky OR of ovf/unf events

Behaviour:
- Reset is asynchronous on the falling edge of reset_n_i and holds while low: count_r_o=reset_val_p; ovf_r_o, unf_r_o, tc_r_o and err_r_o are all 0. Deassertion is synchronous to clk_i (released by the environment). Reset mid-count discards the operation in flight.
- Next-state priority per edge:
  1. set_i=1: count<=val_i. ovf, unf and tc pulses are 0. err holds its value, subject to clear_err_i.
  2. Else up_i=1 and down_i=1: hold the count. All pulses are 0.
  3. Else up_i=1: sum = count + zero-extended step_i, computed at width_p+1 bits. If sum[width_p]=1, this is overflow: wrap mode loads sum[width_p-1:0]; saturate mode loads all-ones; ovf pulse=1.
  4. Else down_i=1: diff = count - step_i, computed at width_p+1 bits. A borrow is underflow: wrap mode loads diff modulo 2^width_p; saturate mode loads 0; unf pulse=1.
  5. Else: hold the count.
- step_i=0 with up_i or down_i: the count holds and no pulse is raised.
- Latency: count_r_o and all *_r_o outputs update on the edge after the request. zero_o follows count_r_o combinationally.
- tc_r_o=1 only when case 4 applied, the previous count was !=0, and the new count==0. This includes a saturating underflow that clamps to 0, in which case unf_r_o=1 in the same cycle. A wrap underflow landing exactly on 0 is impossible. tc is never asserted by set_i or by reset.
- err_r_o: next = (err_r_o & ~clear_err_i) | ovf_next | unf_next. An event in the same cycle as clear_err_i wins, so err stays 1.
- The pulses are registered every cycle, so with no event they return to 0 after one cycle. Back-to-back overflows give back-to-back pulses.
- There are no X on outputs after reset for any input sequence. Inputs are sampled only at the clock edge.
- All arithmetic is unsigned.

Test Plan:
- Reset/load (width_p=16, reset_val_p=0x0005): hold reset_n_i low for 3 edges, then set_i=1 with val_i=0x1234. Required: count_r_o=5 during reset, all flags 0, and count=0x1234 on the edge after set_i.
- Wrap overflow (saturate_p=0): load 0xFFFE, then up_i=1 with step_i=3. Required: count=0x0001, ovf_r_o=1 for exactly one cycle, err_r_o=1 and holding.
- Saturate (saturate_p=1): load 0x0002, then down_i=1 with step_i=5. Required: count=0, unf_r_o=1, tc_r_o=1, err_r_o=1. Next cycle down_i=1 with step_i=1: count stays 0, unf=1, tc=0.
- Priority: set_i=1, up_i=1, step_i=0xF, val_i=0x00AA. Required: count=0x00AA, no pulses. Then up_i=down_i=1: count holds at 0x00AA. Then up_i=1 with step_i=0: count holds, no pulses.
- Terminal count: load 3, then down_i=1 with step_i=1 for 3 cycles. Required: counts 2,1,0; tc_r_o=1 only on the third update; zero_o=1 afterwards.
- Sticky clear: with err_r_o=1, pulse clear_err_i alone and err_r_o returns to 0. Then assert clear_err_i in the same cycle as an overflow: err_r_o=1. Finally assert reset_n_i low asynchronously between edges: all outputs reset immediately.
